// File: rtl/multicycle_controller_if.sv
// Control/status bundle between the multicycle controller and its datapath.
// The controller uses the master modport; the datapath or a testbench uses slave.
interface multicycle_controller_if;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        zero;
  logic        mem_ready;

  logic        ir_we;
  logic        pc_we;
  logic [1:0]  pc_src;
  logic        reg_we;
  logic [1:0]  reg_dst;
  logic [1:0]  mem_to_reg;
  logic        alu_src_b;
  logic [2:0]  alu_op;
  logic        dm_we;
  logic        dm_req;
  logic [2:0]  state;
  logic        instr_done;
  logic [31:0] instr_count;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output ir_we, pc_we, pc_src, reg_we, reg_dst, mem_to_reg, alu_src_b,
           alu_op, dm_we, dm_req, state, instr_done, instr_count
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  ir_we, pc_we, pc_src, reg_we, reg_dst, mem_to_reg, alu_src_b,
           alu_op, dm_we, dm_req, state, instr_done, instr_count
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle MIPS-subset control FSM with a retired-instruction counter.
// Define ILLEGAL_TRAP_EN to trap unsupported instructions into HALT instead of retiring them as NOPs.
//
// state  | meaning
// FETCH  | load IR, PC <= PC+4
// DECODE | register read; J/JAL (and untrapped illegal ops) finish here
// EXEC   | ALU operation; branches and JR finish here
// MEM    | data-memory access, held until mem_ready
// WB     | register-file write-back
// HALT   | illegal-instruction trap, left only by reset
module multicycle_controller (
  input  logic                   clk,
  input  logic                   reset,
  multicycle_controller_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_SLT   = 6'b101010;

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_XOR  = 3'd2;
  localparam logic [2:0] ALU_SLT  = 3'd3;

  localparam logic [1:0] PC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_JUMP   = 2'd1;
  localparam logic [1:0] PC_BRANCH = 2'd2;
  localparam logic [1:0] PC_RS     = 2'd3;

  state_t      state_q;
  state_t      state_d;
  logic [31:0] count_q;

  logic is_rtype, is_add, is_sub, is_slt, is_jr;
  logic is_j, is_jal, is_beq, is_bne, is_addi, is_xori, is_lw, is_sw;
  logic is_legal;

  assign is_rtype = (bus.opcode == OP_RTYPE);
  assign is_add   = is_rtype && (bus.funct == FN_ADD);
  assign is_sub   = is_rtype && (bus.funct == FN_SUB);
  assign is_slt   = is_rtype && (bus.funct == FN_SLT);
  assign is_jr    = is_rtype && (bus.funct == FN_JR);
  assign is_j     = (bus.opcode == OP_J);
  assign is_jal   = (bus.opcode == OP_JAL);
  assign is_beq   = (bus.opcode == OP_BEQ);
  assign is_bne   = (bus.opcode == OP_BNE);
  assign is_addi  = (bus.opcode == OP_ADDI);
  assign is_xori  = (bus.opcode == OP_XORI);
  assign is_lw    = (bus.opcode == OP_LW);
  assign is_sw    = (bus.opcode == OP_SW);

  assign is_legal = is_add || is_sub || is_slt || is_jr || is_j || is_jal ||
                    is_beq || is_bne || is_addi || is_xori || is_lw || is_sw;

  logic       ir_we_c, pc_we_c, reg_we_c, dm_we_c, dm_req_c, done_c;
  logic [1:0] pc_src_c, reg_dst_c, mem_to_reg_c;
  logic       alu_src_b_c;
  logic [2:0] alu_op_c;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      if (done_c) begin
        count_q <= count_q + 32'd1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    ir_we_c      = 1'b0;
    pc_we_c      = 1'b0;
    pc_src_c     = PC_PLUS4;
    reg_we_c     = 1'b0;
    reg_dst_c    = 2'd0;
    mem_to_reg_c = 2'd0;
    alu_src_b_c  = 1'b0;
    alu_op_c     = ALU_ADD;
    dm_we_c      = 1'b0;
    dm_req_c     = 1'b0;
    done_c       = 1'b0;

    case (state_q)
      S_FETCH: begin
        ir_we_c = 1'b1;
        pc_we_c = 1'b1;
        state_d = S_DECODE;
      end

      S_DECODE: begin
        if (is_j) begin
          pc_we_c  = 1'b1;
          pc_src_c = PC_JUMP;
          done_c   = 1'b1;
          state_d  = S_FETCH;
        end else if (is_jal) begin
          pc_we_c      = 1'b1;
          pc_src_c     = PC_JUMP;
          reg_we_c     = 1'b1;
          reg_dst_c    = 2'd2;
          mem_to_reg_c = 2'd2;
          done_c       = 1'b1;
          state_d      = S_FETCH;
        end else if (is_legal) begin
          state_d = S_EXEC;
        end else begin
`ifdef ILLEGAL_TRAP_EN
          state_d = S_HALT;
`else
          done_c  = 1'b1;
          state_d = S_FETCH;
`endif
        end
      end

      S_EXEC: begin
        if (is_sub || is_beq || is_bne) begin
          alu_op_c = ALU_SUB;
        end else if (is_slt) begin
          alu_op_c = ALU_SLT;
        end else if (is_xori) begin
          alu_op_c = ALU_XOR;
        end
        alu_src_b_c = is_addi || is_xori || is_lw || is_sw;

        if (is_beq || is_bne) begin
          pc_we_c  = is_beq ? bus.zero : ~bus.zero;
          pc_src_c = PC_BRANCH;
          done_c   = 1'b1;
          state_d  = S_FETCH;
        end else if (is_jr) begin
          pc_we_c  = 1'b1;
          pc_src_c = PC_RS;
          done_c   = 1'b1;
          state_d  = S_FETCH;
        end else if (is_lw || is_sw) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end

      // The request stays up until the memory acknowledges; only SW retires here.
      S_MEM: begin
        dm_req_c = 1'b1;
        dm_we_c  = is_sw;
        if (bus.mem_ready) begin
          if (is_sw) begin
            done_c  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end

      S_WB: begin
        reg_we_c     = 1'b1;
        reg_dst_c    = is_rtype ? 2'd0 : 2'd1;
        mem_to_reg_c = is_lw ? 2'd1 : 2'd0;
        done_c       = 1'b1;
        state_d      = S_FETCH;
      end

      S_HALT: begin
`ifdef ILLEGAL_TRAP_EN
        state_d = S_HALT;
`else
        state_d = S_FETCH;
`endif
      end

      default: state_d = S_FETCH;
    endcase
  end

  // Strobes are forced low while reset is held, even though state already reads FETCH.
  assign bus.ir_we       = ir_we_c  & ~reset;
  assign bus.pc_we       = pc_we_c  & ~reset;
  assign bus.reg_we      = reg_we_c & ~reset;
  assign bus.dm_we       = dm_we_c  & ~reset;
  assign bus.dm_req      = dm_req_c & ~reset;
  assign bus.instr_done  = done_c   & ~reset;

  assign bus.pc_src      = pc_src_c;
  assign bus.reg_dst     = reg_dst_c;
  assign bus.mem_to_reg  = mem_to_reg_c;
  assign bus.alu_src_b   = alu_src_b_c;
  assign bus.alu_op      = alu_op_c;
  assign bus.state       = state_q;
  assign bus.instr_count = count_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed scenarios plus a randomized
// instruction stream checked against a per-instruction model. Honours ILLEGAL_TRAP_EN.
module tb_multicycle_controller;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_XORI = 6'b001110;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BAD  = 6'b111111;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_JR   = 6'b001000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multicycle_controller_if bus();
  multicycle_controller dut (.clk(clk), .reset(reset), .bus(bus));

  int tests_run = 0;
  int fails = 0;
  logic [31:0] exp_count;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic z, input logic mr);
    bus.opcode    = op;
    bus.funct     = fn;
    bus.zero      = z;
    bus.mem_ready = mr;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    drive(OP_SW, FN_ADD, 1'b0, 1'b1);
    tick; tick;
    tests_run++;
    if (bus.state !== 3'd0) begin fails++; $display("FAIL reset_state got %0d want 0", bus.state); end
    tests_run++;
    if ({bus.ir_we, bus.pc_we, bus.reg_we, bus.dm_we, bus.dm_req, bus.instr_done} !== 6'b0) begin
      fails++; $display("FAIL reset_strobes got %b want 000000",
        {bus.ir_we, bus.pc_we, bus.reg_we, bus.dm_we, bus.dm_req, bus.instr_done});
    end
    tests_run++;
    if (bus.instr_count !== 32'd0) begin fails++; $display("FAIL reset_count got %0d want 0", bus.instr_count); end
    reset = 1'b0;
    exp_count = 32'd0;
    #1;
    tests_run++;
    if (bus.ir_we !== 1'b1 || bus.pc_we !== 1'b1 || bus.pc_src !== 2'd0) begin
      fails++; $display("FAIL fetch_strobes got ir_we=%b pc_we=%b pc_src=%0d want 1 1 0", bus.ir_we, bus.pc_we, bus.pc_src);
    end
  endtask

  task automatic test_add;
    logic [2:0] exp_st [4] = '{3'd0, 3'd1, 3'd2, 3'd4};
    for (int c = 0; c < 4; c++) begin
      drive(OP_R, FN_ADD, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      #1;
      tests_run++;
      if (bus.state !== exp_st[c]) begin fails++; $display("FAIL add_state cyc %0d got %0d want %0d", c, bus.state, exp_st[c]); end
      if (c == 3) begin
        tests_run++;
        if (bus.reg_we !== 1'b1 || bus.reg_dst !== 2'd0 || bus.mem_to_reg !== 2'd0 || bus.instr_done !== 1'b1) begin
          fails++; $display("FAIL add_wb got reg_we=%b reg_dst=%0d m2r=%0d done=%b want 1 0 0 1",
            bus.reg_we, bus.reg_dst, bus.mem_to_reg, bus.instr_done);
        end
      end
      tick;
    end
    exp_count++;
    tests_run++;
    if (bus.instr_count !== exp_count) begin fails++; $display("FAIL add_count got %0d want %0d", bus.instr_count, exp_count); end
  endtask

  task automatic test_lw_wait;
    logic [2:0] exp_st [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd4};
    for (int c = 0; c < 8; c++) begin
      drive(OP_LW, 6'($urandom), 1'b0, (c == 6) || (c < 3 && c != 0 ? 1'b1 : 1'b0));
      #1;
      tests_run++;
      if (bus.state !== exp_st[c]) begin fails++; $display("FAIL lw_state cyc %0d got %0d want %0d", c, bus.state, exp_st[c]); end
      if (c >= 3 && c <= 6) begin
        tests_run++;
        if (bus.dm_req !== 1'b1 || bus.dm_we !== 1'b0) begin
          fails++; $display("FAIL lw_mem cyc %0d got dm_req=%b dm_we=%b want 1 0", c, bus.dm_req, bus.dm_we);
        end
      end
      if (c == 7) begin
        tests_run++;
        if (bus.mem_to_reg !== 2'd1 || bus.reg_dst !== 2'd1 || bus.reg_we !== 1'b1) begin
          fails++; $display("FAIL lw_wb got m2r=%0d reg_dst=%0d reg_we=%b want 1 1 1", bus.mem_to_reg, bus.reg_dst, bus.reg_we);
        end
      end
      tick;
    end
    exp_count++;
    tests_run++;
    if (bus.state !== 3'd0 || bus.instr_count !== exp_count) begin
      fails++; $display("FAIL lw_end got state=%0d count=%0d want 0 %0d", bus.state, bus.instr_count, exp_count);
    end
  endtask

  task automatic test_branches;
    for (int b = 0; b < 2; b++) begin
      for (int c = 0; c < 3; c++) begin
        drive(b == 0 ? OP_BEQ : OP_BNE, 6'($urandom), 1'b0, 1'($urandom_range(0, 1)));
        #1;
        tests_run++;
        if (bus.state !== 3'(c)) begin fails++; $display("FAIL br%0d_state cyc %0d got %0d want %0d", b, c, bus.state, c); end
        if (c == 2) begin
          tests_run++;
          if (bus.pc_we !== 1'(b) || bus.pc_src !== 2'd2 || bus.alu_op !== 3'd1 || bus.instr_done !== 1'b1) begin
            fails++; $display("FAIL br%0d_exec got pc_we=%b pc_src=%0d alu_op=%0d done=%b want %0d 2 1 1",
              b, bus.pc_we, bus.pc_src, bus.alu_op, bus.instr_done, b);
          end
        end
        tick;
      end
      exp_count++;
    end
    tests_run++;
    if (bus.state !== 3'd0 || bus.instr_count !== exp_count) begin
      fails++; $display("FAIL br_end got state=%0d count=%0d want 0 %0d", bus.state, bus.instr_count, exp_count);
    end
  endtask

  task automatic test_jal;
    drive(OP_JAL, 6'($urandom), 1'b1, 1'b1);
    tick;
    #1;
    tests_run++;
    if (bus.state !== 3'd1 || bus.pc_we !== 1'b1 || bus.pc_src !== 2'd1 || bus.reg_we !== 1'b1 ||
        bus.reg_dst !== 2'd2 || bus.mem_to_reg !== 2'd2 || bus.instr_done !== 1'b1) begin
      fails++; $display("FAIL jal_decode got st=%0d pc_we=%b pc_src=%0d reg_we=%b dst=%0d m2r=%0d done=%b want 1 1 1 1 2 2 1",
        bus.state, bus.pc_we, bus.pc_src, bus.reg_we, bus.reg_dst, bus.mem_to_reg, bus.instr_done);
    end
    tick;
    exp_count++;
    tests_run++;
    if (bus.state !== 3'd0 || bus.instr_count !== exp_count) begin
      fails++; $display("FAIL jal_end got state=%0d count=%0d want 0 %0d", bus.state, bus.instr_count, exp_count);
    end
  endtask

  task automatic test_illegal;
    drive(OP_BAD, 6'($urandom), 1'b0, 1'b0);
    tick;
    #1;
`ifdef ILLEGAL_TRAP_EN
    tests_run++;
    if (bus.instr_done !== 1'b0) begin fails++; $display("FAIL ill_decode_done got %b want 0", bus.instr_done); end
    for (int c = 0; c < 3; c++) begin
      tick;
      bus.mem_ready = 1'($urandom_range(0, 1));
      #1;
      tests_run++;
      if (bus.state !== 3'd5 ||
          {bus.ir_we, bus.pc_we, bus.reg_we, bus.dm_we, bus.dm_req, bus.instr_done} !== 6'b0) begin
        fails++; $display("FAIL ill_halt got state=%0d strobes=%b want 5 000000", bus.state,
          {bus.ir_we, bus.pc_we, bus.reg_we, bus.dm_we, bus.dm_req, bus.instr_done});
      end
    end
    tests_run++;
    if (bus.instr_count !== exp_count) begin fails++; $display("FAIL ill_count got %0d want %0d", bus.instr_count, exp_count); end
    reset = 1'b1;
    tick;
    reset = 1'b0;
    exp_count = 32'd0;
    tests_run++;
    if (bus.state !== 3'd0 || bus.instr_count !== 32'd0) begin
      fails++; $display("FAIL ill_recover got state=%0d count=%0d want 0 0", bus.state, bus.instr_count);
    end
`else
    tests_run++;
    if (bus.state !== 3'd1 || bus.instr_done !== 1'b1 || bus.pc_we !== 1'b0 || bus.reg_we !== 1'b0) begin
      fails++; $display("FAIL ill_nop got state=%0d done=%b pc_we=%b reg_we=%b want 1 1 0 0",
        bus.state, bus.instr_done, bus.pc_we, bus.reg_we);
    end
    tick;
    exp_count++;
    tests_run++;
    if (bus.state !== 3'd0 || bus.instr_count !== exp_count) begin
      fails++; $display("FAIL ill_end got state=%0d count=%0d want 0 %0d", bus.state, bus.instr_count, exp_count);
    end
`endif
  endtask

  // Model: each instruction class is described by its path through the states and
  // the totals of each strobe it must produce over its lifetime.
  task automatic test_random(input int n);
    for (int k = 0; k < n; k++) begin
      int cls;
      int w;
      logic z;
      logic [5:0] op, fn;
      logic [2:0] seq [$];
      int pc_we_exp, reg_we_exp, dm_req_exp, dm_we_exp;
      int pc_we_n, reg_we_n, dm_req_n, dm_we_n, mem_i;
      logic [2:0] aop_exp;
      logic asrc_exp;
      bit is_mem, is_wb;

      cls = int'($urandom_range(0, 11));
      w   = int'($urandom_range(0, 3));
      z   = 1'($urandom_range(0, 1));
      fn  = 6'($urandom);
      aop_exp = 3'd0; asrc_exp = 1'b0;
      pc_we_exp = 1; reg_we_exp = 0; dm_req_exp = 0; dm_we_exp = 0;
      case (cls)
        0: begin op = OP_R; fn = FN_ADD; reg_we_exp = 1; end
        1: begin op = OP_R; fn = FN_SUB; reg_we_exp = 1; aop_exp = 3'd1; end
        2: begin op = OP_R; fn = FN_SLT; reg_we_exp = 1; aop_exp = 3'd3; end
        3: begin op = OP_R; fn = FN_JR;  pc_we_exp = 2; end
        4: begin op = OP_J;   pc_we_exp = 2; end
        5: begin op = OP_JAL; pc_we_exp = 2; reg_we_exp = 1; end
        6: begin op = OP_BEQ; pc_we_exp = 1 + int'(z);  aop_exp = 3'd1; end
        7: begin op = OP_BNE; pc_we_exp = 1 + int'(!z); aop_exp = 3'd1; end
        8: begin op = OP_ADDI; reg_we_exp = 1; asrc_exp = 1'b1; end
        9: begin op = OP_XORI; reg_we_exp = 1; aop_exp = 3'd2; asrc_exp = 1'b1; end
        10: begin op = OP_LW; reg_we_exp = 1; asrc_exp = 1'b1; dm_req_exp = w + 1; end
        default: begin op = OP_SW; asrc_exp = 1'b1; dm_req_exp = w + 1; dm_we_exp = w + 1; end
      endcase
      is_mem = (cls >= 10);
      is_wb  = (cls <= 2) || cls == 8 || cls == 9 || cls == 10;

      seq.push_back(3'd0);
      seq.push_back(3'd1);
      if (cls != 4 && cls != 5) seq.push_back(3'd2);
      if (is_mem) for (int m = 0; m <= w; m++) seq.push_back(3'd3);
      if (is_wb) seq.push_back(3'd4);

      pc_we_n = 0; reg_we_n = 0; dm_req_n = 0; dm_we_n = 0; mem_i = 0;
      for (int c = 0; c < seq.size(); c++) begin
        if (seq[c] == 3'd3) begin
          drive(op, fn, z, mem_i == w);
          mem_i++;
        end else begin
          drive(op, fn, z, 1'($urandom_range(0, 1)));
        end
        #1;
        tests_run++;
        if (bus.state !== seq[c] || bus.instr_done !== (c == seq.size() - 1)) begin
          fails++; $display("FAIL rnd_step cls %0d cyc %0d got state=%0d done=%b want %0d %0d",
            cls, c, bus.state, bus.instr_done, seq[c], c == seq.size() - 1);
        end
        if (seq[c] == 3'd2) begin
          tests_run++;
          if (bus.alu_op !== aop_exp || bus.alu_src_b !== asrc_exp) begin
            fails++; $display("FAIL rnd_alu cls %0d got op=%0d src=%b want %0d %b", cls, bus.alu_op, bus.alu_src_b, aop_exp, asrc_exp);
          end
        end
        pc_we_n  += int'(bus.pc_we);
        reg_we_n += int'(bus.reg_we);
        dm_req_n += int'(bus.dm_req);
        dm_we_n  += int'(bus.dm_we);
        tick;
      end
      exp_count++;
      tests_run++;
      if (pc_we_n != pc_we_exp || reg_we_n != reg_we_exp || dm_req_n != dm_req_exp || dm_we_n != dm_we_exp) begin
        fails++; $display("FAIL rnd_totals cls %0d got pc_we=%0d reg_we=%0d dm_req=%0d dm_we=%0d want %0d %0d %0d %0d",
          cls, pc_we_n, reg_we_n, dm_req_n, dm_we_n, pc_we_exp, reg_we_exp, dm_req_exp, dm_we_exp);
      end
      tests_run++;
      if (bus.instr_count !== exp_count) begin
        fails++; $display("FAIL rnd_count cls %0d got %0d want %0d", cls, bus.instr_count, exp_count);
      end
    end
  endtask

  task automatic test_reset_mid_mem;
    for (int c = 0; c < 4; c++) begin
      drive(OP_SW, 6'($urandom), 1'b0, 1'b0);
      #1;
      tests_run++;
      if (bus.state !== 3'(c)) begin fails++; $display("FAIL sw_state cyc %0d got %0d want %0d", c, bus.state, c); end
      if (c < 3) tick;
    end
    tests_run++;
    if (bus.dm_req !== 1'b1 || bus.dm_we !== 1'b1) begin
      fails++; $display("FAIL sw_mem got dm_req=%b dm_we=%b want 1 1", bus.dm_req, bus.dm_we);
    end
    reset = 1'b1;
    bus.mem_ready = 1'b1;
    #1;
    tests_run++;
    if (bus.dm_we !== 1'b0 || bus.dm_req !== 1'b0 || bus.instr_done !== 1'b0) begin
      fails++; $display("FAIL sw_reset_strobes got dm_we=%b dm_req=%b done=%b want 0 0 0", bus.dm_we, bus.dm_req, bus.instr_done);
    end
    tick;
    tests_run++;
    if (bus.state !== 3'd0 || bus.instr_count !== 32'd0 || bus.dm_we !== 1'b0) begin
      fails++; $display("FAIL sw_reset_end got state=%0d count=%0d dm_we=%b want 0 0 0", bus.state, bus.instr_count, bus.dm_we);
    end
    reset = 1'b0;
    exp_count = 32'd0;
  endtask

  initial begin
    reset = 1'b1;
    drive(OP_R, FN_ADD, 1'b0, 1'b0);
    exp_count = 32'd0;
    test_reset();
    test_add();
    test_lw_wait();
    test_branches();
    test_jal();
    test_illegal();
    test_random(300);
    test_reset_mid_mem();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 opcode  input  6  instruction[31:26] from the instruction register; stable from DECODE to instruction end.
REQ-004 funct  input  6  instruction[5:0]; used only when opcode=000000.
REQ-005 zero  input  1  ALU zero flag, valid in EXEC.
REQ-006 mem_ready  input  1  data-memory completion handshake.
REQ-007 ir_we  output  1  instruction-register load strobe.
REQ-008 pc_we  output  1  PC load strobe.
REQ-009 pc_src  output  2  next-PC select: 0 PC+4, 1 jump target, 2 branch target, 3 rs.
REQ-010 reg_we  output  1  register-file write strobe.
REQ-011 reg_dst  output  2  destination select: 0 rd, 1 rt, 2 r31.
REQ-012 mem_to_reg  output  2  write-data select: 0 ALU, 1 memory, 2 PC+4.
REQ-013 alu_src_b  output  1  0 register rt, 1 sign-extended immediate.
REQ-014 alu_op  output  3  0 add, 1 sub, 2 xor, 3 slt.
REQ-015 dm_we  output  1  data-memory write enable.
REQ-016 dm_req  output  1  data-memory access request.
REQ-017 state  output  3  current state: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
REQ-018 instr_done  output  1  one-cycle pulse in the final cycle of each instruction.
REQ-019 instr_count  output  32  retired-instruction counter.

Function
REQ-020 Strobes SHALL be combinational decodes of registered state plus opcode/funct/zero; state transitions SHALL be registered.
REQ-021 FETCH: ir_we=1, pc_we=1, pc_src=0; next DECODE.
REQ-022 DECODE, J: pc_we=1, pc_src=1, instr_done=1; next FETCH (2 cycles total).
REQ-023 DECODE, JAL: pc_we=1, pc_src=1, reg_we=1, reg_dst=2, mem_to_reg=2, instr_done=1; next FETCH.
REQ-024 DECODE, all other legal opcodes: no strobes; next EXEC.
REQ-025 EXEC: alu_op/alu_src_b SHALL be ADD=0/0, SUB=1/0, SLT=3/0, ADDI=0/1, XORI=2/1, LW/SW=0/1, BEQ/BNE=1/0.
REQ-026 EXEC, BEQ: pc_we=zero, pc_src=2; BNE: pc_we=~zero, pc_src=2; both assert instr_done; next FETCH (3 cycles).
REQ-027 EXEC, JR (opcode 0, funct 001000): pc_we=1, pc_src=3, instr_done=1; next FETCH.
REQ-028 EXEC: LW/SW next MEM; R-type ALU ops, ADDI and XORI next WB.
REQ-029 MEM: dm_req=1, with dm_we=1 for SW, held until the cycle mem_ready=1; the state SHALL stay MEM while mem_ready=0.
REQ-030 MEM with mem_ready=1: SW asserts instr_done, next FETCH; LW next WB.
REQ-031 WB: reg_we=1, instr_done=1; reg_dst=0 for R-type, else 1; mem_to_reg=1 for LW, else 0; next FETCH.
REQ-032 instr_count SHALL increment by 1 on each cycle with instr_done=1, wrapping from 0xFFFFFFFF to 0.
REQ-033 mem_ready outside MEM SHALL be ignored.
REQ-034 Undriven selects SHALL be 0 in any state not listed for them.

Reset
REQ-035 reset=1 at a clock edge SHALL force state=FETCH and instr_count=0.
REQ-036 While reset=1, all strobes (ir_we, pc_we, reg_we, dm_we, dm_req, instr_done) SHALL be 0.
REQ-037 Reset during MEM SHALL abandon the access; no instr_done and no count increment for it.

Configuration
REQ-038 Macro ILLEGAL_TRAP_EN: when defined, an unsupported opcode or R-type funct in DECODE SHALL move to HALT, where all strobes are 0 and the block stays until reset.
REQ-039 Without ILLEGAL_TRAP_EN, an unsupported instruction SHALL retire as a NOP in DECODE (instr_done=1, next FETCH), and HALT SHALL be unreachable.

Verification
REQ-040 ADD (opcode 0, funct 100000) -> states 0,1,2,4; reg_we=1 and reg_dst=0 in WB; instr_count +1.
REQ-041 LW with mem_ready low for 3 cycles -> MEM held 4 cycles with dm_req=1 and dm_we=0; WB mem_to_reg=1; 8 cycles total.
REQ-042 BEQ with zero=0, then BNE with zero=0 -> BEQ pc_we=0; BNE pc_we=1 and pc_src=2; each takes 3 cycles.
REQ-043 JAL -> DECODE asserts pc_we, reg_we, reg_dst=2, mem_to_reg=2; 2 cycles total.
REQ-044 Reset asserted mid-MEM of SW -> next state FETCH, dm_we=0, instr_count=0.
REQ-045 Opcode 111111 -> HALT (state=5) with ILLEGAL_TRAP_EN defined; without it, NOP retire with instr_count +1.
